// File: rtl/mac_table_pkg.sv
// Shared types and helpers for the MAC learning table.
package mac_table_pkg;

    localparam int MAC_W = 48;

    typedef enum logic [2:0] {
        NEW     = 3'd0,
        REFRESH = 3'd1,
        MOVE    = 3'd2,
        EVICT   = 3'd3,
        DROP    = 3'd4
    } learn_result_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2
    } learn_state_e;

    // I/G bit is the LSB of the first octet, which sits at bit 40.
    function automatic logic is_group_mac(input logic [MAC_W-1:0] mac);
        return mac[40];
    endfunction

endpackage

// File: rtl/mac_table_store.sv
// MAC table storage: per-entry valid/MAC/port/hit counter, write port,
// saturating hit increments, flush and valid-entry count.
module mac_table_store
    import mac_table_pkg::*;
#(
    parameter int NUM_PORTS   = 8,
    parameter int NUM_ENTRIES = 64,
    parameter int HIT_W       = 8,
    localparam int PORT_W     = $clog2(NUM_PORTS),
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [MAC_W-1:0]  wr_mac,
    input  logic [PORT_W-1:0] wr_port,
    input  logic              wr_clear_hits,
    input  logic              wr_count,
    input  logic              hit_inc_en,
    input  logic [IDX_W-1:0]  hit_inc_idx,
    output logic              tbl_valid [NUM_ENTRIES],
    output logic [MAC_W-1:0]  tbl_mac   [NUM_ENTRIES],
    output logic [PORT_W-1:0] tbl_port  [NUM_ENTRIES],
    output logic [HIT_W-1:0]  tbl_hits  [NUM_ENTRIES],
    output logic [IDX_W:0]    num_valid
);

    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    logic [IDX_W:0] num_valid_q, num_valid_d;

    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
        logic              valid_q, valid_d;
        logic [MAC_W-1:0]  mac_q,   mac_d;
        logic [PORT_W-1:0] port_q,  port_d;
        logic [HIT_W-1:0]  hits_q,  hits_d;

        // Priority: flush over write over increment, so a NEW/EVICT zeroes hits
        // while a MOVE (no clear) keeps a same-cycle increment.
        always_comb begin
            valid_d = valid_q;
            mac_d   = mac_q;
            port_d  = port_q;
            hits_d  = hits_q;
            if (hit_inc_en && hit_inc_idx == IDX_W'(gi) && valid_q && hits_q != HIT_MAX)
                hits_d = hits_q + HIT_W'(1);
            if (wr_en && wr_idx == IDX_W'(gi)) begin
                valid_d = 1'b1;
                mac_d   = wr_mac;
                port_d  = wr_port;
                if (wr_clear_hits)
                    hits_d = '0;
            end
            if (flush) begin
                valid_d = 1'b0;
                hits_d  = '0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_q <= 1'b0;
                mac_q   <= '0;
                port_q  <= '0;
                hits_q  <= '0;
            end else begin
                valid_q <= valid_d;
                mac_q   <= mac_d;
                port_q  <= port_d;
                hits_q  <= hits_d;
            end
        end

        assign tbl_valid[gi] = valid_q;
        assign tbl_mac[gi]   = mac_q;
        assign tbl_port[gi]  = port_q;
        assign tbl_hits[gi]  = hits_q;
    end

    always_comb begin
        num_valid_d = num_valid_q;
        if (wr_en && wr_count)
            num_valid_d = num_valid_q + (IDX_W+1)'(1);
        if (flush)
            num_valid_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            num_valid_q <= '0;
        else
            num_valid_q <= num_valid_d;
    end

    assign num_valid = num_valid_q;

endmodule

// File: rtl/mac_learn_writer.sv
// Learn engine: accepts source-MAC learn requests, scans the table one entry
// per cycle, then refreshes, moves, inserts or evicts.
module mac_learn_writer
    import mac_table_pkg::*;
#(
    parameter int NUM_PORTS   = 8,
    parameter int NUM_ENTRIES = 64,
    parameter int HIT_W       = 8,
    localparam int PORT_W     = $clog2(NUM_PORTS),
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              learn_valid,
    output logic              learn_ready,
    input  logic [MAC_W-1:0]  learn_mac,
    input  logic [PORT_W-1:0] learn_port,
    output logic              learn_done,
    output learn_result_e     learn_result,
    output logic [IDX_W-1:0]  learn_idx,
    input  logic              flush,
    input  logic              hit_inc_en,
    input  logic [IDX_W-1:0]  hit_inc_idx,
    output logic              tbl_valid [NUM_ENTRIES],
    output logic [MAC_W-1:0]  tbl_mac   [NUM_ENTRIES],
    output logic [PORT_W-1:0] tbl_port  [NUM_ENTRIES],
    output logic [HIT_W-1:0]  tbl_hits  [NUM_ENTRIES],
    output logic [IDX_W:0]    num_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    learn_state_e      state_q, state_d;
    logic [MAC_W-1:0]  mac_q, mac_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic              free_found_q, free_found_d;
    logic [IDX_W-1:0]  free_idx_q, free_idx_d;
    logic [HIT_W-1:0]  min_hits_q, min_hits_d;
    logic [IDX_W-1:0]  min_idx_q, min_idx_d;
    logic              match_q, match_d;
    logic [IDX_W-1:0]  match_idx_q, match_idx_d;
    logic              drop_q, drop_d;

    logic              wr_en, wr_clear_hits, wr_count;
    logic [IDX_W-1:0]  wr_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mac_q        <= '0;
            port_q       <= '0;
            scan_idx_q   <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            min_hits_q   <= '1;
            min_idx_q    <= '0;
            match_q      <= 1'b0;
            match_idx_q  <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mac_q        <= mac_d;
            port_q       <= port_d;
            scan_idx_q   <= scan_idx_d;
            free_found_q <= free_found_d;
            free_idx_q   <= free_idx_d;
            min_hits_q   <= min_hits_d;
            min_idx_q    <= min_idx_d;
            match_q      <= match_d;
            match_idx_q  <= match_idx_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mac_d        = mac_q;
        port_d       = port_q;
        scan_idx_d   = scan_idx_q;
        free_found_d = free_found_q;
        free_idx_d   = free_idx_q;
        min_hits_d   = min_hits_q;
        min_idx_d    = min_idx_q;
        match_d      = match_q;
        match_idx_d  = match_idx_q;
        drop_d       = drop_q;
        unique case (state_q)
            ST_IDLE: begin
                if (learn_valid) begin
                    mac_d   = learn_mac;
                    port_d  = learn_port;
                    match_d = 1'b0;
                    if (is_group_mac(learn_mac)) begin
                        drop_d  = 1'b1;
                        state_d = ST_WRITE;
                    end else begin
                        drop_d       = 1'b0;
                        scan_idx_d   = '0;
                        free_found_d = 1'b0;
                        free_idx_d   = '0;
                        min_hits_d   = '1;
                        min_idx_d    = '0;
                        state_d      = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (tbl_valid[scan_idx_q] && tbl_mac[scan_idx_q] == mac_q) begin
                    match_d     = 1'b1;
                    match_idx_d = scan_idx_q;
                    state_d     = ST_WRITE;
                end else begin
                    if (!tbl_valid[scan_idx_q] && !free_found_q) begin
                        free_found_d = 1'b1;
                        free_idx_d   = scan_idx_q;
                    end
                    // Strict less-than keeps the lowest index on ties.
                    if (tbl_valid[scan_idx_q] && tbl_hits[scan_idx_q] < min_hits_q) begin
                        min_hits_d = tbl_hits[scan_idx_q];
                        min_idx_d  = scan_idx_q;
                    end
                    if (scan_idx_q == LAST_IDX)
                        state_d = ST_WRITE;
                    else
                        scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush)
            state_d = ST_IDLE;
    end

    always_comb begin
        learn_ready   = (state_q == ST_IDLE);
        learn_done    = 1'b0;
        learn_result  = DROP;
        learn_idx     = '0;
        wr_en         = 1'b0;
        wr_clear_hits = 1'b0;
        wr_count      = 1'b0;
        wr_idx        = '0;
        if (state_q == ST_WRITE && !flush) begin
            learn_done = 1'b1;
            if (!drop_q) begin
                if (match_q) begin
                    learn_idx = match_idx_q;
                    wr_idx    = match_idx_q;
                    if (tbl_port[match_idx_q] != port_q) begin
                        learn_result = MOVE;
                        wr_en        = 1'b1;
                    end else begin
                        learn_result = REFRESH;
                    end
                end else if (free_found_q) begin
                    learn_result  = NEW;
                    learn_idx     = free_idx_q;
                    wr_idx        = free_idx_q;
                    wr_en         = 1'b1;
                    wr_clear_hits = 1'b1;
                    wr_count      = 1'b1;
                end else begin
                    learn_result  = EVICT;
                    learn_idx     = min_idx_q;
                    wr_idx        = min_idx_q;
                    wr_en         = 1'b1;
                    wr_clear_hits = 1'b1;
                end
            end
        end
    end

    mac_table_store #(
        .NUM_PORTS  (NUM_PORTS),
        .NUM_ENTRIES(NUM_ENTRIES),
        .HIT_W      (HIT_W)
    ) u_store (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_mac       (mac_q),
        .wr_port      (port_q),
        .wr_clear_hits(wr_clear_hits),
        .wr_count     (wr_count),
        .hit_inc_en   (hit_inc_en),
        .hit_inc_idx  (hit_inc_idx),
        .tbl_valid    (tbl_valid),
        .tbl_mac      (tbl_mac),
        .tbl_port     (tbl_port),
        .tbl_hits     (tbl_hits),
        .num_valid    (num_valid)
    );

endmodule

// File: tb/tb_mac_learn_writer.sv
// Directed bench: a 64-entry table and a 4-entry table driven in sequence.
module tb_mac_learn_writer;
    import mac_table_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        lv0 = 1'b0, hie0 = 1'b0;
    logic [47:0] lm0 = '0;
    logic [2:0]  lp0 = '0;
    logic [5:0]  hii0 = '0;
    logic        lr0, ld0;
    logic [2:0]  lres0;
    logic [5:0]  lidx0;
    logic        tv0 [64];
    logic [47:0] tm0 [64];
    logic [2:0]  tp0 [64];
    logic [7:0]  th0 [64];
    logic [6:0]  nv0;

    logic        lv4 = 1'b0, hie4 = 1'b0;
    logic [47:0] lm4 = '0;
    logic [2:0]  lp4 = '0;
    logic [1:0]  hii4 = '0;
    logic        lr4, ld4;
    logic [2:0]  lres4;
    logic [1:0]  lidx4;
    logic        tv4 [4];
    logic [47:0] tm4 [4];
    logic [2:0]  tp4 [4];
    logic [7:0]  th4 [4];
    logic [2:0]  nv4;

    mac_learn_writer dut (
        .clk(clk), .reset(reset),
        .learn_valid(lv0), .learn_ready(lr0), .learn_mac(lm0), .learn_port(lp0),
        .learn_done(ld0), .learn_result(lres0), .learn_idx(lidx0),
        .flush(flush), .hit_inc_en(hie0), .hit_inc_idx(hii0),
        .tbl_valid(tv0), .tbl_mac(tm0), .tbl_port(tp0), .tbl_hits(th0),
        .num_valid(nv0)
    );

    mac_learn_writer #(.NUM_ENTRIES(4)) dut4 (
        .clk(clk), .reset(reset),
        .learn_valid(lv4), .learn_ready(lr4), .learn_mac(lm4), .learn_port(lp4),
        .learn_done(ld4), .learn_result(lres4), .learn_idx(lidx4),
        .flush(flush), .hit_inc_en(hie4), .hit_inc_idx(hii4),
        .tbl_valid(tv4), .tbl_mac(tm4), .tbl_port(tp4), .tbl_hits(th4),
        .num_valid(nv4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents one request, waits for done (bounded), returns result/idx/latency.
    task automatic learn(input int s, input logic [47:0] mac, input logic [2:0] port,
                         input bit hold, output logic [2:0] res, output int idx,
                         output int lat, output bit rdy_seen);
        @(negedge clk);
        if (s == 0) begin lv0 = 1'b1; lm0 = mac; lp0 = port; end
        else        begin lv4 = 1'b1; lm4 = mac; lp4 = port; end
        @(posedge clk); #1;
        if (!hold) begin lv0 = 1'b0; lv4 = 1'b0; end
        lat = 1;
        rdy_seen = 1'b0;
        while (((s == 0) ? ld0 : ld4) !== 1'b1 && lat < 200) begin
            if (((s == 0) ? lr0 : lr4) === 1'b1) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        res = (s == 0) ? lres0 : lres4;
        idx = (s == 0) ? int'(lidx0) : int'(lidx4);
        lv0 = 1'b0;
        lv4 = 1'b0;
        @(posedge clk); #1;
        $display("learn dut%0d mac=%012h port=%0d -> res=%0d idx=%0d lat=%0d", s, mac, port, res, idx, lat);
    endtask

    task automatic hit(input int s, input int idx, input int n);
        @(negedge clk);
        if (s == 0) begin hie0 = 1'b1; hii0 = 6'(idx); end
        else        begin hie4 = 1'b1; hii4 = 2'(idx); end
        repeat (n) @(negedge clk);
        hie0 = 1'b0;
        hie4 = 1'b0;
        $display("hit dut%0d idx=%0d x%0d", s, idx, n);
    endtask

    logic [2:0] res;
    int idx, lat;
    bit rdy;
    bit seen_done;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", lr0, 1);
        check("rst_done", ld0, 0);
        check("rst_result", lres0, DROP);
        check("rst_idx", lidx0, 0);
        check("rst_nv", nv0, 0);
        check("rst_valid0", tv0[0], 0);
        check("rst_nv4", nv4, 0);

        // First learn on an empty table, request held through the scan
        learn(0, 48'h020000000001, 3'd3, 1'b1, res, idx, lat, rdy);
        check("new_res", res, NEW);
        check("new_idx", idx, 0);
        check("new_lat", lat, 65);
        check("new_no_ready_in_scan", rdy, 0);
        check("new_ready_after", lr0, 1);
        check("new_no_reaccept", ld0, 0);
        check("new_port", tp0[0], 3);
        check("new_valid", tv0[0], 1);
        check("new_nv", nv0, 1);

        hit(0, 0, 2);
        check("hits_two", th0[0], 2);
        learn(0, 48'h020000000001, 3'd3, 1'b0, res, idx, lat, rdy);
        check("refresh_res", res, REFRESH);
        check("refresh_idx", idx, 0);
        check("refresh_lat", lat, 2);
        check("refresh_hits", th0[0], 2);
        learn(0, 48'h020000000001, 3'd5, 1'b0, res, idx, lat, rdy);
        check("move_res", res, MOVE);
        check("move_idx", idx, 0);
        check("move_port", tp0[0], 5);
        check("move_hits", th0[0], 2);
        check("move_nv", nv0, 1);

        learn(0, 48'h01005E000001, 3'd1, 1'b0, res, idx, lat, rdy);
        check("drop_res", res, DROP);
        check("drop_idx", idx, 0);
        check("drop_lat", lat, 1);
        check("drop_nv", nv0, 1);
        check("drop_valid1", tv0[1], 0);

        hit(0, 0, 300);
        check("hits_sat", th0[0], 255);
        hit(0, 10, 1);
        check("hits_invalid", th0[10], 0);
        check("hits_invalid_valid", tv0[10], 0);

        learn(0, 48'h020000000002, 3'd1, 1'b0, res, idx, lat, rdy);
        check("new2_res", res, NEW);
        check("new2_idx", idx, 1);
        check("new2_nv", nv0, 2);
        learn(0, 48'h020000000002, 3'd1, 1'b0, res, idx, lat, rdy);
        check("refresh_k1_res", res, REFRESH);
        check("refresh_k1_lat", lat, 3);

        // Small table: fill, bias hit counts, then force evictions
        for (int i = 0; i < 4; i++) begin
            learn(1, 48'h020000000010 + 48'(i), 3'(i), 1'b0, res, idx, lat, rdy);
            check("fill_idx", idx, i);
            check("fill_res", res, NEW);
        end
        check("fill_lat", lat, 5);
        check("fill_nv4", nv4, 4);
        hit(1, 0, 2);
        hit(1, 1, 2);
        hit(1, 3, 2);
        hit(1, 2, 1);
        check("hits4_2", th4[2], 1);
        learn(1, 48'h020000000020, 3'd4, 1'b0, res, idx, lat, rdy);
        check("evict_res", res, EVICT);
        check("evict_idx", idx, 2);
        check("evict_lat", lat, 5);
        check("evict_hits", th4[2], 0);
        check("evict_mac", tm4[2], 48'h020000000020);
        check("evict_port", tp4[2], 4);
        check("evict_nv4", nv4, 4);
        hit(1, 2, 2);
        learn(1, 48'h020000000021, 3'd6, 1'b0, res, idx, lat, rdy);
        check("tie_res", res, EVICT);
        check("tie_idx", idx, 0);
        check("tie_mac", tm4[0], 48'h020000000021);
        check("tie_hits1", th4[1], 2);

        // Flush in the middle of a scan
        @(negedge clk);
        lv0 = 1'b1; lm0 = 48'h020000000099; lp0 = 3'd2;
        @(negedge clk);
        lv0 = 1'b0;
        check("scan_not_ready", lr0, 0);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", lr0, 1);
        check("flush_nv", nv0, 0);
        check("flush_valid0", tv0[0], 0);
        check("flush_hits0", th0[0], 0);
        check("flush_nv4", nv4, 0);
        seen_done = 1'b0;
        repeat (80) begin @(negedge clk); if (ld0) seen_done = 1'b1; end
        check("flush_no_done", seen_done, 0);
        $display("flush mid-scan done");

        // Asynchronous reset in the middle of a scan
        learn(0, 48'h020000000077, 3'd6, 1'b0, res, idx, lat, rdy);
        check("post_flush_res", res, NEW);
        check("post_flush_idx", idx, 0);
        @(negedge clk);
        lv0 = 1'b1; lm0 = 48'h020000000088; lp0 = 3'd1;
        @(negedge clk);
        lv0 = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_nv_async", nv0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("arst_ready", lr0, 1);
        check("arst_valid0", tv0[0], 0);
        check("arst_result", lres0, DROP);
        seen_done = 1'b0;
        repeat (80) begin @(negedge clk); if (ld0) seen_done = 1'b1; end
        check("arst_no_done", seen_done, 0);
        $display("reset mid-scan done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_learn_writer.md
Name: mac_learn_writer

Overview:
- Write side of the switch MAC address table. Owns the table storage: valid bit, 48-bit MAC, egress port and hit counter per entry.
- Accepts source-MAC learn requests from ingress parsing and scans the table one entry per cycle. Then refreshes the matching entry, moves it to a new port, inserts into a free slot, or evicts the least-hit entry.
- Exports the table contents to the lookup block. Takes hit-increment strobes back from the lookup block.

Parameters:
- NUM_PORTS, 8, number of switch ports; PORT_W = $clog2(NUM_PORTS)
- NUM_ENTRIES, 64, table depth; IDX_W = $clog2(NUM_ENTRIES)
- HIT_W, 8, hit counter width; saturates at 2^HIT_W-1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- learn_valid  in  1  learn request valid
- learn_ready  out  1  high only in IDLE
- learn_mac  in  48  source MAC; [47:40] is the first octet
- learn_port  in  PORT_W  ingress port of the frame
- learn_done  out  1  one-cycle completion pulse
- learn_result  out  3  result code: NEW / REFRESH / MOVE / EVICT / DROP
- learn_idx  out  IDX_W  entry written; 0 on DROP
- flush  in  1  invalidate whole table
- hit_inc_en  in  1  lookup hit strobe
- hit_inc_idx  in  IDX_W  entry that was hit
- tbl_valid  out  [NUM_ENTRIES] x 1  entry valid
- tbl_mac  out  [NUM_ENTRIES] x 48  entry MAC
- tbl_port  out  [NUM_ENTRIES] x PORT_W  entry port
- tbl_hits  out  [NUM_ENTRIES] x HIT_W  entry hit count
- num_valid  out  IDX_W+1  count of valid entries

Behaviour:
- Reset (async, active-low): state IDLE; all tbl_* zero; learn_done=0, learn_result=DROP, learn_idx=0, num_valid=0; learn_ready=1 once out of reset.
- FSM states: IDLE, SCAN, WRITE.
- IDLE:
  - learn_valid & learn_ready latches mac and port.
  - If mac bit 40 = 1 (group address): go to WRITE with result DROP, no table change.
  - Otherwise go to SCAN with scan_idx=0, free_found=0, min_hits=all-ones, min_idx=0.
- SCAN examines entry scan_idx each cycle:
  - valid & MAC equal: record match_idx, go to WRITE next cycle (early exit).
  - !valid & !free_found: record free_idx, set free_found.
  - valid & hits < min_hits: record min_idx, min_hits. Strict less-than, so ties resolve to the lowest index.
  - After scan_idx = NUM_ENTRIES-1 with no match: go to WRITE.
  - The scan uses live table values. A hit_inc landing during the scan may leave min selection stale; this is accepted.
- WRITE (one cycle), priority order:
  - DROP.
  - match: port differs → update port, result MOVE; port equal → result REFRESH. Hits unchanged in both cases.
  - free_found → write MAC, port, valid=1, hits=0 at free_idx; result NEW.
  - otherwise → overwrite min_idx, hits=0; result EVICT.
  - learn_done=1 with result and index in the WRITE cycle. Next state IDLE.
- Latency:
  - Request accepted at cycle T.
  - Match at index k: done at T+2+k.
  - No match: done at T+1+NUM_ENTRIES.
  - DROP: done at T+1.
  - learn_ready reasserts at the cycle after done.
- Hit counter:
  - hit_inc_en with tbl_valid[idx]=1: hits+1, saturating at max.
  - hit_inc_en to an invalid entry: ignored.
  - Same cycle as a NEW/EVICT write to the same idx: write wins, hits=0.
  - Same cycle as a REFRESH/MOVE to the same idx: increment applies.
- num_valid: +1 on NEW; unchanged on EVICT, MOVE, REFRESH; 0 on flush.
- flush, accepted in any state:
  - Clears all tbl_valid and tbl_hits; MAC and port contents are don't-care.
  - Aborts any in-progress learn: return to IDLE, no done pulse.
  - flush overrides a same-cycle WRITE and hit_inc.
- Reset mid-scan: immediate return to reset state; the request is lost.

Decomposition:
- Package mac_table_pkg:
  - MAC_W=48
  - learn_result_e enum: NEW=0, REFRESH=1, MOVE=2, EVICT=3, DROP=4
  - learn_state_e enum
  - is_group_mac() function (bit 40 test)
- Sub-module mac_table_store:
  - Holds the storage arrays, write port, saturating hit-increment port, flush and num_valid.
  - The top level holds the FSM and scan trackers.

Test Plan:
- Reset, then learn 02:00:00:00:00:01 on port 3 → done at T+1+64, result NEW, idx 0, tbl_port[0]=3, num_valid=1.
- Re-learn the same MAC on port 3, then on port 5 → REFRESH idx 0 at T+2, then MOVE idx 0 with tbl_port[0]=5; hits preserved.
- Learn 01:00:5E:00:00:01 → DROP at T+1, table unchanged; learn_valid held during SCAN sees learn_ready=0 and no second accept.
- NUM_ENTRIES=4: fill entries; hit_inc entries 0, 1, 3 twice each, entry 2 once; learn a new MAC → EVICT idx 2 with hits[2]=0. Then tie case with all hits equal → evicts idx 0.
- Drive hit_inc on one entry 300 times with HIT_W=8 → saturates at 255. hit_inc to an invalid idx → no change.
- Assert flush mid-SCAN → no done pulse, all tbl_valid=0, num_valid=0, learn_ready=1 the next cycle. Async reset mid-SCAN → same result.
